// File: rtl/game_pkg.sv
// Shared game definitions: player FSM state encoding, sprite_control bit
// positions, screen geometry and a small animation helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_RISE = 2'd2,
    ST_FALL = 2'd3
  } player_state_t;

  // sprite_control = {face_right, airborne, idle, frame[3:0]}
  localparam int SC_FACE_RIGHT = 6;
  localparam int SC_AIRBORNE   = 5;
  localparam int SC_IDLE       = 4;
  localparam int SC_FRAME_MSB  = 3;
  localparam int SC_FRAME_LSB  = 0;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  // Advance an animation frame, wrapping after the last frame index.
  function automatic logic [3:0] frame_next(input logic [3:0] f, input logic [3:0] last);
    logic [3:0] r;
    if (f >= last) begin
      r = 4'd0;
    end else begin
      r = f + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/player_kinematics_ctrl_rate_divider.sv
// Programmable rate divider: counts enabled clocks and pulses tick on the
// cycle the count reaches div-1. The ">=" terminal compare keeps a divider
// that shrinks at runtime from overshooting into a long wrap-around.
module rate_divider
  import game_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_s;

  assign term_s = (div == '0) ? '0 : (div - CNT_W'(1));
  assign tick   = en & ~clr & (cnt_q >= term_s);

  // Next count: clear wins, wrap on tick, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_kinematics_ctrl.sv
// Player movement controller: walk, variable-height jump and accelerating
// fall, with registered sprite coordinates and sprite_control.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra jump while airborne).
module player_kinematics_ctrl
  import game_pkg::*;
#(
  parameter int X_SPAWN      = 100,
  parameter int Y_SPAWN      = 500,
  parameter int W            = 32,
  parameter int H            = 32,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = SCREEN_W - 1,
  parameter int Y_FLOOR      = SCREEN_H - 1,
  parameter int JUMP_HEIGHT  = 200,
  parameter int WALK_DIV     = 400_000,
  parameter int AIR_DIV      = 700_000,
  parameter int RISE_DIV0    = 200_000,
  parameter int RISE_DIV_MAX = 800_000,
  parameter int FALL_DIV0    = 800_000,
  parameter int FALL_DIV_MIN = 150_000,
  parameter int DIV_STEP     = 20_000,
  parameter int ANIM_FRAMES  = 8,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       respawn,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  input  logic       on_ground,
  input  logic       hit_ceiling,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [6:0] sprite_control,
  output logic       airborne
);

  localparam logic [9:0]       X_SPAWN_C      = 10'(X_SPAWN);
  localparam logic [9:0]       Y_SPAWN_C      = 10'(Y_SPAWN);
  localparam logic [9:0]       X_LO_C         = 10'(X_MIN);
  localparam logic [9:0]       X_HI_C         = 10'(X_MAX - W);
  localparam logic [9:0]       Y_LAND_C       = 10'(Y_FLOOR - H);
  localparam logic [11:0]      JUMP_H_C       = 12'(JUMP_HEIGHT);
  localparam logic [11:0]      KNEE_C         = 12'(JUMP_HEIGHT * 7 / 8);
  localparam logic [CNT_W-1:0] WALK_DIV_C     = CNT_W'(WALK_DIV);
  localparam logic [CNT_W-1:0] AIR_DIV_C      = CNT_W'(AIR_DIV);
  localparam logic [CNT_W-1:0] RISE_DIV0_C    = CNT_W'(RISE_DIV0);
  localparam logic [CNT_W-1:0] RISE_DIV_MAX_C = CNT_W'(RISE_DIV_MAX);
  localparam logic [CNT_W-1:0] FALL_DIV0_C    = CNT_W'(FALL_DIV0);
  localparam logic [CNT_W-1:0] FALL_DIV_MIN_C = CNT_W'(FALL_DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_STEP_C     = CNT_W'(DIV_STEP);
  localparam logic [3:0]       FRAME_LAST_C   = 4'(ANIM_FRAMES - 1);

  player_state_t    state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d, y_start_q, y_start_d;
  logic [CNT_W-1:0] rise_div_q, rise_div_d, fall_div_q, fall_div_d;
  logic             face_q, face_d;
  logic [3:0]       frame_q, frame_d;
  logic [2:0]       walk_px_q, walk_px_d;
  logic             jump_q;

  logic             dir_onehot_s, jump_edge_s, grounded_s, in_air_s;
  logic             rise_stop_s, knee_s, enter_rise_s, enter_fall_s, dj_avail_s;
  logic             x_clr_s, x_tick_s, y_clr_s, y_tick_s;
  logic [CNT_W-1:0] x_div_s, y_div_s;
  logic [CNT_W:0]   rise_sum_s, fall_diff_s;

  assign dir_onehot_s = left ^ right;
  assign jump_edge_s  = jump & ~jump_q;
  assign grounded_s   = on_ground | (y_q == Y_LAND_C);
  assign in_air_s     = (state_q == ST_RISE) | (state_q == ST_FALL);
  // Compare in 12 bits with the offset on the y side so nothing goes negative.
  assign rise_stop_s  = (({2'b00, y_q} + JUMP_H_C) == {2'b00, y_start_q}) | hit_ceiling
                        | ~jump | (y_q == 10'd0);
  assign knee_s       = ({2'b00, y_q} - 12'd1 + KNEE_C) <= {2'b00, y_start_q};
  assign rise_sum_s   = {1'b0, rise_div_q} + {1'b0, DIV_STEP_C};
  assign fall_diff_s  = {1'b0, fall_div_q} - {1'b0, DIV_STEP_C};
  assign enter_fall_s = (state_d == ST_FALL) & (state_q != ST_FALL);

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic dj_used_q, dj_used_d;
  assign dj_avail_s = ~dj_used_q;
  // The air jump is spent on any RISE entry made while airborne; landing re-arms it.
  assign dj_used_d  = ((state_q == ST_FALL) && (state_d == ST_IDLE)) ? 1'b0
                      : (dj_used_q | (in_air_s & enter_rise_s));

  // Double-jump bookkeeping register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dj_used_q <= 1'b0;
    end else if (respawn) begin
      dj_used_q <= 1'b0;
    end else begin
      dj_used_q <= dj_used_d;
    end
  end
`else
  assign dj_avail_s = 1'b0;
`endif

  // Horizontal divider runs only with a single direction held; both/neither clears it.
  assign x_clr_s = respawn | ~dir_onehot_s;
  assign x_div_s = in_air_s ? AIR_DIV_C : WALK_DIV_C;
  // Vertical divider restarts on every state change or jump re-entry.
  assign y_clr_s = respawn | ~in_air_s | enter_rise_s | (state_d != state_q);
  assign y_div_s = (state_q == ST_RISE) ? rise_div_q : fall_div_q;

  rate_divider #(.CNT_W(CNT_W)) u_div_x (
    .clk (clk), .rst (rst), .en (dir_onehot_s), .clr (x_clr_s), .div (x_div_s), .tick (x_tick_s)
  );

  rate_divider #(.CNT_W(CNT_W)) u_div_y (
    .clk (clk), .rst (rst), .en (in_air_s), .clr (y_clr_s), .div (y_div_s), .tick (y_tick_s)
  );

  // Next-state logic for the movement FSM.
  always_comb begin
    state_d      = state_q;
    enter_rise_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_WALK: begin
        if (jump_edge_s && grounded_s) begin
          state_d      = ST_RISE;
          enter_rise_s = 1'b1;
        end else if (!grounded_s) begin
          state_d = ST_FALL;
        end else if (dir_onehot_s) begin
          state_d = ST_WALK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RISE: begin
        if (jump_edge_s && dj_avail_s) begin
          state_d      = ST_RISE;
          enter_rise_s = 1'b1;
        end else if (rise_stop_s) begin
          state_d = ST_FALL;
        end else begin
          state_d = ST_RISE;
        end
      end
      ST_FALL: begin
        if (grounded_s) begin
          state_d = ST_IDLE;
        end else if (jump_edge_s && dj_avail_s) begin
          state_d      = ST_RISE;
          enter_rise_s = 1'b1;
        end else begin
          state_d = ST_FALL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: position steps, divider ramps and animation.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    y_start_d  = y_start_q;
    rise_div_d = rise_div_q;
    fall_div_d = fall_div_q;
    face_d     = face_q;
    frame_d    = frame_q;
    walk_px_d  = walk_px_q;

    if (dir_onehot_s) begin
      face_d = right;
    end else begin
      face_d = face_q;
    end

    if (x_tick_s) begin
      if (right && (x_q < X_HI_C)) begin
        x_d = x_q + 10'd1;
      end else if (left && (x_q > X_LO_C)) begin
        x_d = x_q - 10'd1;
      end else begin
        x_d = x_q;
      end
      if (in_air_s) begin
        frame_d = frame_next(frame_q, FRAME_LAST_C);
      end else if (state_q == ST_WALK) begin
        walk_px_d = walk_px_q + 3'd1;
        frame_d   = (walk_px_q == 3'd7) ? frame_next(frame_q, FRAME_LAST_C) : frame_q;
      end else begin
        frame_d = frame_q;
      end
    end else begin
      x_d = x_q;
    end

    if (enter_rise_s) begin
      y_start_d  = y_q;
      rise_div_d = RISE_DIV0_C;
    end else if (enter_fall_s) begin
      fall_div_d = (state_q == ST_RISE) ? rise_div_q : FALL_DIV0_C;
    end else if (y_tick_s && (state_q == ST_RISE)) begin
      y_d = y_q - 10'd1;
      if (knee_s) begin
        rise_div_d = (rise_sum_s >= {1'b0, RISE_DIV_MAX_C}) ? RISE_DIV_MAX_C
                                                            : rise_sum_s[CNT_W-1:0];
      end else begin
        rise_div_d = rise_div_q;
      end
    end else if (y_tick_s && (state_q == ST_FALL)) begin
      y_d        = (y_q < Y_LAND_C) ? (y_q + 10'd1) : y_q;
      fall_div_d = (fall_diff_s[CNT_W] || (fall_diff_s[CNT_W-1:0] < FALL_DIV_MIN_C))
                   ? FALL_DIV_MIN_C : fall_diff_s[CNT_W-1:0];
    end else begin
      y_d = y_q;
    end
  end

  // State and datapath registers; respawn overrides everything but reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;  x_q <= X_SPAWN_C;  y_q <= Y_SPAWN_C;  y_start_q <= Y_SPAWN_C;
      rise_div_q <= '0;  fall_div_q <= '0;  face_q <= 1'b1;  frame_q <= 4'd0;  walk_px_q <= 3'd0;
    end else if (respawn) begin
      state_q <= ST_IDLE;  x_q <= X_SPAWN_C;  y_q <= Y_SPAWN_C;  y_start_q <= Y_SPAWN_C;
      rise_div_q <= '0;  fall_div_q <= '0;  face_q <= 1'b1;  frame_q <= 4'd0;  walk_px_q <= 3'd0;
    end else begin
      state_q <= state_d;  x_q <= x_d;  y_q <= y_d;  y_start_q <= y_start_d;
      rise_div_q <= rise_div_d;  fall_div_q <= fall_div_d;  face_q <= face_d;
      frame_q <= frame_d;  walk_px_q <= walk_px_d;
    end
  end

  // Previous jump level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_q <= 1'b0;
    end else begin
      jump_q <= jump;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign airborne = in_air_s;
  assign sprite_control[SC_FACE_RIGHT]             = face_q;
  assign sprite_control[SC_AIRBORNE]               = in_air_s;
  assign sprite_control[SC_IDLE]                   = (state_q == ST_IDLE);
  assign sprite_control[SC_FRAME_MSB:SC_FRAME_LSB] = frame_q;

endmodule
